instr_fetch_queue: RTL
======================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32, instruction/PC width.
REQ-002 SHALL have parameter DEPTH, default 4, prefetch queue entries (power of two, >=2).
REQ-003 SHALL have parameter RESET_PC, default 0, PC value after reset.
REQ-004 SHALL have parameter HALT_OP, default 4'hF, opcode (bits [31:28]) that halts fetch.
REQ-005 SHALL have one clock and a synchronous active-high reset: CLK input 1, rising-edge clock; RST input 1, synchronous active-high reset.
REQ-006 SHALL have port imem_req output 1, fetch request valid this cycle.
REQ-007 SHALL have port imem_addr output BUS_WIDTH, word address of request (current PC).
REQ-008 SHALL have port imem_rvalid input 1, response valid, exactly one cycle after an accepted imem_req.
REQ-009 SHALL have port imem_rdata input BUS_WIDTH, fetched instruction.
REQ-010 SHALL have port stall_D input 1, decode cannot accept; hold InstrD.
REQ-011 SHALL have port redirect_en input 1, flush and restart fetch at redirect_pc.
REQ-012 SHALL have port redirect_pc input BUS_WIDTH, new fetch address.
REQ-013 SHALL have port InstrD output BUS_WIDTH, registered instruction to decode (32'b0 = bubble).
REQ-014 SHALL have port PCD output BUS_WIDTH, PC of InstrD.
REQ-015 SHALL have port InstrD_valid output 1, InstrD carries a real instruction.
REQ-016 SHALL have port halted output 1, fetch stopped by HALT_OP.

Function
REQ-017 SHALL implement states RUN and HALTED; RUN->HALTED when a HALT_OP instruction is loaded into InstrD; HALTED->RUN only on redirect_en.
REQ-018 SHALL assert imem_req (combinational) iff state==RUN, RST==0, redirect_en==0, and count+inflight < DEPTH (count, inflight both registered values).
REQ-019 SHALL increment PC by 1 on each cycle imem_req==1; PC wraps modulo 2^BUS_WIDTH.
REQ-020 SHALL push {imem_rdata, request PC} into the queue on imem_rvalid unless the response belongs to a request issued before the latest redirect or HALT entry (discarded).
REQ-021 SHALL, on each rising edge with stall_D==0 and no redirect: pop queue head into InstrD/PCD with InstrD_valid=1 if non-empty; else InstrD=0, PCD unchanged, InstrD_valid=0.
REQ-022 SHALL hold InstrD, PCD, InstrD_valid unchanged when stall_D==1; queue keeps filling up to the credit limit.
REQ-023 SHALL support push and pop in the same cycle, including push into a full-then-popped queue; push to a full queue without pop SHALL be impossible by REQ-018.
REQ-024 SHALL, on redirect_en (overrides stall_D): empty the queue, set PC=redirect_pc, InstrD=0, InstrD_valid=0, state=RUN, discard the in-flight response; first new request issues the next cycle.
REQ-025 SHALL, on entering HALTED: empty the queue, discard in-flight response, set halted=1; subsequent non-stalled cycles output bubbles.
REQ-026 SHALL give two-cycle minimum latency from imem_req to InstrD update (response cycle, then pop edge).

Reset
REQ-027 SHALL, while RST==1 at a rising edge: PC=RESET_PC, queue empty, inflight=0, InstrD=0, PCD=RESET_PC, InstrD_valid=0, state=RUN, halted=0; imem_req=0 while RST==1.
REQ-028 SHALL discard any response arriving in the cycle after reset (reset mid-fetch).

Verification
REQ-029 Reset release, memory returns word i at address i, stall_D=0 -> imem_addr 0,1,2,...; InstrD=word0 with PCD=0 two cycles after first request, then one per cycle.
REQ-030 stall_D=1 for 6 cycles in steady stream -> InstrD held; imem_req stops after count+inflight=4; on release entries pop in order with no loss or duplicate.
REQ-031 redirect_en with redirect_pc=0x40 while queue holds 3 entries and one in flight -> next InstrD=0/valid=0; no stale word appears; first valid InstrD has PCD=0x40.
REQ-032 Word at address 5 has opcode 4'hF -> InstrD=that word, halted=1, imem_req=0 thereafter, InstrD=0 bubbles; redirect_pc=0x10 resumes with PCD=0x10.
REQ-033 RST asserted for one cycle mid-stream with stall_D=1 -> all outputs per REQ-027; response in following cycle discarded; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_fetch_queue : credit-limited instruction prefetch queue feeding decode
// Revision 1.0
// ---------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter int                   BUS_WIDTH = 32,
  parameter int                   DEPTH     = 4,
  parameter logic [BUS_WIDTH-1:0] RESET_PC  = '0,
  parameter logic [3:0]           HALT_OP   = 4'hF
) (
  input  logic                 CLK,
  input  logic                 RST,
  output logic                 imem_req,
  output logic [BUS_WIDTH-1:0] imem_addr,
  input  logic                 imem_rvalid,
  input  logic [BUS_WIDTH-1:0] imem_rdata,
  input  logic                 stall_D,
  input  logic                 redirect_en,
  input  logic [BUS_WIDTH-1:0] redirect_pc,
  output logic [BUS_WIDTH-1:0] InstrD,
  output logic [BUS_WIDTH-1:0] PCD,
  output logic                 InstrD_valid,
  output logic                 halted
);

  localparam int                 PTR_W   = $clog2(DEPTH);
  localparam int                 CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0]     DEPTH_C = (CNT_W + 1)'(DEPTH);
  localparam logic [0:0]         ST_RUN    = 1'b0;
  localparam logic [0:0]         ST_HALTED = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [BUS_WIDTH-1:0] pc_q, pc_d;
  logic [BUS_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                 inflight_q, inflight_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [BUS_WIDTH-1:0] qi_q [DEPTH];
  logic [BUS_WIDTH-1:0] qi_d [DEPTH];
  logic [BUS_WIDTH-1:0] qp_q [DEPTH];
  logic [BUS_WIDTH-1:0] qp_d [DEPTH];
  logic [BUS_WIDTH-1:0] instr_q, instr_d;
  logic [BUS_WIDTH-1:0] pcd_q, pcd_d;
  logic                 valid_q, valid_d;

  logic [CNT_W:0]       used;
  logic                 resp_ok, advance, head_valid, load, bypass;
  logic                 push, pop, halt_enter, flush;
  logic [BUS_WIDTH-1:0] load_instr, load_pc;

  // Credit counts both queued entries and the single outstanding request.
  assign used      = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign imem_req  = (state_q == ST_RUN) && !RST && !redirect_en && (used < DEPTH_C);
  assign imem_addr = pc_q;

  assign resp_ok    = imem_rvalid && inflight_q;
  assign advance    = !stall_D && !redirect_en;
  assign head_valid = (count_q != '0);
  assign load       = advance && (head_valid || resp_ok);
  assign bypass     = advance && !head_valid && resp_ok;
  assign load_instr = head_valid ? qi_q[rd_ptr_q] : imem_rdata;
  assign load_pc    = head_valid ? qp_q[rd_ptr_q] : req_pc_q;
  assign halt_enter = load && (state_q == ST_RUN) &&
                      (load_instr[BUS_WIDTH-1 -: 4] == HALT_OP);
  assign push       = resp_ok && !redirect_en && !bypass && !halt_enter;
  assign pop        = advance && head_valid;
  assign flush      = redirect_en || halt_enter;

  always_comb begin
    qi_d     = qi_q;
    qp_d     = qp_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      qi_d[wr_ptr_q] = imem_rdata;
      qp_d[wr_ptr_q] = req_pc_q;
      wr_ptr_d       = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    state_d    = state_q;
    inflight_d = imem_req && !halt_enter;
    if (imem_req) begin
      pc_d     = pc_q + BUS_WIDTH'(1);
      req_pc_d = pc_q;
    end
    if (redirect_en) begin
      pc_d    = redirect_pc;
      state_d = ST_RUN;
    end else if (halt_enter) begin
      state_d = ST_HALTED;
    end
  end

  always_comb begin
    instr_d = instr_q;
    pcd_d   = pcd_q;
    valid_d = valid_q;
    if (redirect_en) begin
      instr_d = '0;
      valid_d = 1'b0;
    end else if (!stall_D) begin
      if (load) begin
        instr_d = load_instr;
        pcd_d   = load_pc;
        valid_d = 1'b1;
      end else begin
        instr_d = '0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    qi_q <= qi_d;
    qp_q <= qp_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      instr_q    <= '0;
      pcd_q      <= RESET_PC;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      instr_q    <= instr_d;
      pcd_q      <= pcd_d;
      valid_q    <= valid_d;
    end
  end

  assign InstrD       = instr_q;
  assign PCD          = pcd_q;
  assign InstrD_valid = valid_q;
  assign halted       = (state_q == ST_HALTED);

endmodule
`default_nettype wire
